// File: rtl/uart_rx_deserializer.sv
// UART receive datapath: synchroniser, start/data/parity/stop FSM and
// word assembly with parity and framing flags.
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 sample_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_perror,
    output logic                 rx_ferror,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bitcnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic                 perr;
    logic                 ferr;

    always_comb begin
        shreg_nxt = shreg;
        if (MSB_FIRST != 0)
            shreg_nxt = {shreg[DATA_BITS-2:0], rx_s};
        else
            shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            cnt       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_perror <= 1'b0;
            rx_ferror <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sync1    <= rx_in;
            rx_s     <= sync1;
            rx_valid <= 1'b0;
            if (sample_enable) begin
                cnt <= cnt + 1'b1;
                unique case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= START;
                            busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt == CNT_MID) begin
                            cnt    <= '0;
                            bitcnt <= '0;
                            perr   <= 1'b0;
                            ferr   <= 1'b0;
                            // line back high at mid start bit: a glitch
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (cnt == CNT_LAST) begin
                            cnt    <= '0;
                            shreg  <= shreg_nxt;
                            bitcnt <= bitcnt + 1'b1;
                            if (bitcnt == BIT_LAST) begin
                                bitcnt <= '0;
                                state  <= (PARITY_EN != 0) ? PARITY : STOP;
                            end
                        end
                    end
                    PARITY: begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            perr  <= ((^shreg) ^ rx_s) != ODD;
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (cnt == CNT_LAST) begin
                            cnt    <= '0;
                            bitcnt <= bitcnt + 1'b1;
                            if (!rx_s)
                                ferr <= 1'b1;
                            if (bitcnt == STOP_LAST) begin
                                rx_data   <= shreg;
                                rx_perror <= perr;
                                rx_ferror <= ferr | ~rx_s;
                                rx_valid  <= 1'b1;
                                busy      <= 1'b0;
                                state     <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer across four parameter sets
// sharing one clock, reset and oversample tick.
module tb_uart_rx_deserializer;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       se;
    logic [3:0] rx;
    logic [3:0] v;
    logic [3:0] b;
    logic [3:0] pe;
    logic [3:0] fe;
    logic [7:0] dat0;
    logic [7:0] dat1;
    logic [6:0] dat2;
    logic [7:0] dat3;

    int         ncmp = 0;
    int         nerr = 0;
    int         vcnt [4] = '{default: 0};
    logic [3:0] vbusy = '0;

    always #5 clk = ~clk;

    uart_rx_deserializer u0 (
        .clk(clk), .reset(reset), .rx_in(rx[0]), .sample_enable(se),
        .rx_data(dat0), .rx_valid(v[0]), .rx_perror(pe[0]),
        .rx_ferror(fe[0]), .busy(b[0])
    );

    uart_rx_deserializer #(.PARITY_ODD(1)) u1 (
        .clk(clk), .reset(reset), .rx_in(rx[1]), .sample_enable(se),
        .rx_data(dat1), .rx_valid(v[1]), .rx_perror(pe[1]),
        .rx_ferror(fe[1]), .busy(b[1])
    );

    uart_rx_deserializer #(
        .DATA_BITS(7), .MSB_FIRST(1), .PARITY_EN(0)
    ) u2 (
        .clk(clk), .reset(reset), .rx_in(rx[2]), .sample_enable(se),
        .rx_data(dat2), .rx_valid(v[2]), .rx_perror(pe[2]),
        .rx_ferror(fe[2]), .busy(b[2])
    );

    uart_rx_deserializer #(.STOP_BITS(2)) u3 (
        .clk(clk), .reset(reset), .rx_in(rx[3]), .sample_enable(se),
        .rx_data(dat3), .rx_valid(v[3]), .rx_perror(pe[3]),
        .rx_ferror(fe[3]), .busy(b[3])
    );

    // count valid pulses and note busy while valid is high
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                vcnt[i] = vcnt[i] + 1;
                vbusy[i] = b[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            se = 1'b1;
            @(negedge clk);
            se = 1'b0;
        end
    endtask

    // bits[0] goes on the line first
    task automatic send_bits(input int d, input logic [15:0] bits,
                             input int n);
        for (int i = 0; i < n; i++) begin
            rx[d] = bits[i];
            ticks(OS);
        end
        rx[d] = 1'b1;
    endtask

    logic [15:0] f;

    initial begin
        reset = 1'b1;
        se    = 1'b0;
        rx    = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(dat0), 32'h0);
        chk("rst_valid", 32'(v), 32'h0);
        chk("rst_busy", 32'(b), 32'h0);
        chk("rst_err", 32'({pe, fe}), 32'h0);
        reset = 1'b0;
        ticks(4);

        // 0x5A, even parity 0, stop 1
        f = {5'b0, 1'b1, 1'b0, 8'h5A, 1'b0};
        send_bits(0, f, 5);
        chk("t1_busy_mid", 32'(b[0]), 32'h1);
        chk("t1_hidden", 32'(dat0), 32'h0);
        send_bits(0, f >> 5, 6);
        chk("t1_data", 32'(dat0), 32'h5A);
        chk("t1_perr", 32'(pe[0]), 32'h0);
        chk("t1_ferr", 32'(fe[0]), 32'h0);
        chk("t1_vcnt", 32'(vcnt[0]), 32'h1);
        chk("t1_busy_at_valid", 32'(vbusy[0]), 32'h0);
        chk("t1_busy_end", 32'(b[0]), 32'h0);
        ticks(8);

        // wrong parity bit under even parity
        send_bits(0, {5'b0, 1'b1, 1'b1, 8'h5A, 1'b0}, 11);
        chk("t2_data", 32'(dat0), 32'h5A);
        chk("t2_perr", 32'(pe[0]), 32'h1);
        chk("t2_vcnt", 32'(vcnt[0]), 32'h2);

        // parity bit 1 is correct under odd parity
        send_bits(1, {5'b0, 1'b1, 1'b1, 8'h5A, 1'b0}, 11);
        chk("t2o_data", 32'(dat1), 32'h5A);
        chk("t2o_perr", 32'(pe[1]), 32'h0);
        chk("t2o_vcnt", 32'(vcnt[1]), 32'h1);

        // MSB first, 7 bits, no parity: serial 1,0,1,0,0,1,1
        send_bits(2, {7'b0, 1'b1, 7'b1100101, 1'b0}, 9);
        chk("t3_data", 32'(dat2), 32'h53);
        chk("t3_vcnt", 32'(vcnt[2]), 32'h1);
        chk("t3_perr", 32'(pe[2]), 32'h0);

        // short low glitch is rejected
        ticks(8);
        rx[0] = 1'b0;
        ticks(5);
        rx[0] = 1'b1;
        chk("t4_busy_glitch", 32'(b[0]), 32'h1);
        ticks(OS);
        chk("t4_busy_after", 32'(b[0]), 32'h0);
        chk("t4_vcnt", 32'(vcnt[0]), 32'h2);
        chk("t4_data", 32'(dat0), 32'h5A);

        // two stop bits, second low, then 0xA5 back to back
        send_bits(3, {4'b0, 2'b01, 1'b0, 8'h33, 1'b0}, 12);
        chk("t5_data", 32'(dat3), 32'h33);
        chk("t5_ferr", 32'(fe[3]), 32'h1);
        chk("t5_vcnt", 32'(vcnt[3]), 32'h1);
        send_bits(3, {4'b0, 2'b11, 1'b0, 8'hA5, 1'b0}, 12);
        chk("t5b_data", 32'(dat3), 32'hA5);
        chk("t5b_ferr", 32'(fe[3]), 32'h0);
        chk("t5b_perr", 32'(pe[3]), 32'h0);
        chk("t5b_vcnt", 32'(vcnt[3]), 32'h2);
        ticks(8);

        // reset in the middle of the data bits
        send_bits(0, {12'b0, 3'b101, 1'b0}, 4);
        chk("t6_busy_pre", 32'(b[0]), 32'h1);
        rx[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_rst_data", 32'(dat0), 32'h0);
        chk("t6_rst_busy", 32'(b[0]), 32'h0);
        chk("t6_rst_flags", 32'({v[0], pe[0], fe[0]}), 32'h0);
        repeat (2) @(negedge clk);
        rx[0] = 1'b1;
        reset = 1'b0;
        ticks(4);
        chk("t6_vcnt_abort", 32'(vcnt[0]), 32'h2);
        send_bits(0, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
        chk("t6_data", 32'(dat0), 32'h3C);
        chk("t6_vcnt", 32'(vcnt[0]), 32'h3);
        chk("t6_err", 32'({pe[0], fe[0]}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
Parametrised UART receive datapath that replaces the fixed 8-bit receive shift register. It takes the serial line and the oversample tick from the baud generator, and runs its own start/data/parity/stop state machine. It assembles DATA_BITS-wide words LSB- or MSB-first and presents each word with a one-cycle valid pulse plus parity and framing error flags. It sits between the baud-rate tick generator and the receiver's output register or FIFO.

Parameters:
DATA_BITS, 8, word width (5..9 legal)
OVERSAMPLE, 16, sample_enable ticks per bit period (even, >=4)
MSB_FIRST, 0, 0 = first data bit lands in rx_data[0]; 1 = first data bit lands in rx_data[DATA_BITS-1]
PARITY_EN, 1, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits checked (1 or 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_in  input  1  raw serial line, idle high, asynchronous to clk
sample_enable  input  1  oversample tick, one clk wide, OVERSAMPLE per bit period
rx_data  output  DATA_BITS  last received word
rx_valid  output  1  one-cycle pulse: rx_data and error flags updated
rx_perror  output  1  parity mismatch on last word
rx_ferror  output  1  a stop bit sampled low on last word
busy  output  1  high while not in IDLE

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state IDLE; rx_data 0; rx_valid 0; rx_perror 0; rx_ferror 0; busy 0; both synchroniser flops 1; tick counter 0; bit counter 0.
- Synchroniser: rx_in passes through 2 flops (rx_s). All decisions use rx_s, which adds 2 clk of latency.
- Tick counter cnt: 0..OVERSAMPLE-1. It advances only on sample_enable cycles.
- State machine: IDLE, START, DATA, PARITY, STOP. All transitions occur only on sample_enable cycles.
- IDLE:
  - rx_s==0 on a tick -> START, cnt<=0.
- START:
  - At cnt==OVERSAMPLE/2-1 (mid start bit):
    - rx_s==1 -> false start, return to IDLE. No rx_valid.
    - else -> DATA, cnt<=0, bitcnt<=0.
- DATA:
  - At cnt==OVERSAMPLE-1, sample rx_s (mid-bit). Shift it into the holding register and increment bitcnt. cnt wraps to 0.
  - MSB_FIRST=0: shift right, new bit enters at [DATA_BITS-1].
  - MSB_FIRST=1: shift left, new bit enters at [0].
  - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY:
  - At cnt==OVERSAMPLE-1, latch perr = (XOR of data bits ^ sampled bit) != PARITY_ODD. Then -> STOP.
- STOP:
  - Each stop bit is sampled at cnt==OVERSAMPLE-1. Any low sample sets ferr.
  - After STOP_BITS samples:
    - Load rx_data from the holding register; load rx_perror/rx_ferror.
    - Pulse rx_valid for exactly one clk, on the cycle after the final stop sample tick.
    - Return to IDLE.
- Framing error: the word is still delivered with rx_ferror=1. If the line is still low, IDLE sees it as a new start edge on the next tick. This is the required behaviour; no break detection.
- Holding: rx_data, rx_perror and rx_ferror hold until the next rx_valid. The holding register is not visible on rx_data mid-frame.
- Ticks: sample_enable low freezes all state except the synchroniser.
- Reset mid-frame: immediately returns to IDLE with reset values. The partial word is discarded and no rx_valid is issued.
- Overrun: none. A consumer missing the rx_valid pulse loses the word.

Test Plan:
- Defaults, 0x5A sent LSB-first (start 0, bits 0,1,0,1,1,0,1,0, parity 0, stop 1) -> one rx_valid pulse, rx_data=0x5A, rx_perror=0, rx_ferror=0, busy falls with rx_valid.
- Same frame with parity bit 1 -> rx_data=0x5A, rx_perror=1; then PARITY_ODD=1 with parity 1 -> rx_perror=0.
- MSB_FIRST=1, DATA_BITS=7, PARITY_EN=0; serial bits 1,0,1,0,0,1,1 -> rx_data=7'h53.
- Glitch: rx_in low for 5 ticks then high -> busy pulses, returns to IDLE, no rx_valid, rx_data unchanged.
- STOP_BITS=2, second stop bit driven low -> rx_valid with rx_ferror=1, data correct. Then back-to-back frame 0xA5 -> second rx_valid, rx_data=0xA5, rx_ferror=0.
- Reset asserted mid-DATA (after 3 bits), then released and a clean 0x3C frame sent -> no rx_valid for the aborted frame, outputs 0 during reset, then rx_data=0x3C.
